// File: rtl/convolver_stream_strided.sv
// KxK signed fixed-point convolution over a raster pixel stream with line buffers, stride,
// valid/ready flow control, round-half-up and saturation. Define RELU_EN to clamp negatives to zero.
module convolver_stream_strided #(
  parameter int IMAGE_SIZE  = 28,
  parameter int KERNEL_SIZE = 5,
  parameter int DATA_WIDTH  = 16,
  parameter int FRAC_BIT    = 8,
  parameter int STRIDE      = 1
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] weights_matrix,
  input  logic [DATA_WIDTH-1:0]                         bias,
  input  logic [DATA_WIDTH-1:0]                         pixel_in,
  input  logic                                          pixel_valid,
  output logic                                          pixel_ready,
  output logic [DATA_WIDTH-1:0]                         conv_final_result,
  output logic                                          enable_signal,
  input  logic                                          out_ready,
  output logic                                          frame_done
);
  localparam int K    = KERNEL_SIZE;
  localparam int DW   = DATA_WIDTH;
  localparam int SW   = 2*DW + $clog2(K*K);
  localparam int AW   = SW + 2;
  localparam int CW   = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;
  localparam int PW   = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam int LAST = (K-1) + ((IMAGE_SIZE-K)/STRIDE)*STRIDE;
  localparam logic signed [AW-1:0] RND  = {{(AW-1){1'b0}}, 1'b1} << (FRAC_BIT-1);
  localparam logic signed [AW-1:0] MAXV = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV = ~MAXV;

  logic [CW-1:0]        col_q, col_d, row_q, row_d;
  logic [PW-1:0]        cph_q, cph_d, rph_q, rph_d;
  logic                 s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
  logic signed [SW-1:0] s1_sum_q, s1_sum_d;
  logic [DW-1:0]        res_q, res_d;
  logic                 en_q, en_d, done_q, done_d;

  logic signed [DW-1:0] lb_q  [K-1][IMAGE_SIZE];
  logic signed [DW-1:0] win_q [K][K-1];
  logic signed [DW-1:0] colv_s [K];
  logic signed [DW-1:0] full_s [K][K];
  logic signed [SW-1:0] sum_s;
  logic signed [AW-1:0] acc_s, shf_s;
  logic [DW-1:0]        sat_s, out_s;
  logic                 pipe_en_s, accept_s, win_ok_s, last_s;

  function automatic logic [PW-1:0] ph_inc(input logic [PW-1:0] p);
    if (p == PW'(STRIDE-1)) return {PW{1'b0}};
    else return p + PW'(1);
  endfunction

  assign pipe_en_s         = ~en_q | out_ready;
  assign pixel_ready       = reset & pipe_en_s;
  assign accept_s          = pixel_valid & pixel_ready;
  assign conv_final_result = res_q;
  assign enable_signal     = en_q;
  assign frame_done        = done_q;

  // Phase counters track the stride alignment so no modulo is needed on row/col.
  assign win_ok_s = accept_s && (row_q >= CW'(K-1)) && (col_q >= CW'(K-1)) &&
                    (rph_q == {PW{1'b0}}) && (cph_q == {PW{1'b0}});
  assign last_s   = (row_q == CW'(LAST)) && (col_q == CW'(LAST));

  // Assemble the full window: stored columns plus the incoming column.
  always_comb begin
    for (int r = 0; r < K-1; r++) colv_s[r] = lb_q[K-2-r][col_q];
    colv_s[K-1] = pixel_in;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K-1; c++) full_s[r][c] = win_q[r][c];
      full_s[r][K-1] = colv_s[r];
    end
  end

  // Multiply-accumulate over the window; w[0][0] pairs with the top-left pixel.
  always_comb begin
    sum_s = {SW{1'b0}};
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        sum_s = sum_s + SW'(full_s[r][c]) *
                SW'($signed(weights_matrix[((K*K-1)-(r*K+c))*DW +: DW]));
      end
    end
  end

  // Bias, round half-up, rescale, saturate and optional ReLU.
  always_comb begin
    acc_s = AW'(s1_sum_q) + (AW'($signed(bias)) <<< FRAC_BIT) + RND;
    shf_s = acc_s >>> FRAC_BIT;
    if (shf_s > MAXV)      sat_s = {1'b0, {(DW-1){1'b1}}};
    else if (shf_s < MINV) sat_s = {1'b1, {(DW-1){1'b0}}};
    else                   sat_s = shf_s[DW-1:0];
`ifdef RELU_EN
    if (sat_s[DW-1]) out_s = {DW{1'b0}};
    else             out_s = sat_s;
`else
    out_s = sat_s;
`endif
  end

  // Raster position and stride phase next-state.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    cph_d = cph_q;
    rph_d = rph_q;
    if (accept_s) begin
      if (col_q == CW'(IMAGE_SIZE-1)) begin
        col_d = {CW{1'b0}};
        cph_d = {PW{1'b0}};
        if (row_q == CW'(IMAGE_SIZE-1)) begin
          row_d = {CW{1'b0}};
          rph_d = {PW{1'b0}};
        end else begin
          row_d = row_q + CW'(1);
          if (row_q >= CW'(K-1)) rph_d = ph_inc(rph_q);
          else                   rph_d = rph_q;
        end
      end else begin
        col_d = col_q + CW'(1);
        if (col_q >= CW'(K-1)) cph_d = ph_inc(cph_q);
        else                   cph_d = cph_q;
      end
    end else begin
      col_d = col_q;
    end
  end

  // Pipeline next-state: every stage moves only when the output slot is free.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sum_d   = s1_sum_q;
    s1_last_d  = s1_last_q;
    res_d      = res_q;
    en_d       = en_q;
    done_d     = done_q;
    if (pipe_en_s) begin
      s1_valid_d = win_ok_s;
      s1_sum_d   = sum_s;
      s1_last_d  = last_s;
      en_d       = s1_valid_q;
      done_d     = s1_valid_q & s1_last_q;
      if (s1_valid_q) res_d = out_s;
      else            res_d = res_q;
    end else begin
      en_d = en_q;
    end
  end

  // Control and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_q      <= {CW{1'b0}};
      row_q      <= {CW{1'b0}};
      cph_q      <= {PW{1'b0}};
      rph_q      <= {PW{1'b0}};
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_sum_q   <= {SW{1'b0}};
      res_q      <= {DW{1'b0}};
      en_q       <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      cph_q      <= cph_d;
      rph_q      <= rph_d;
      s1_valid_q <= s1_valid_d;
      s1_last_q  <= s1_last_d;
      s1_sum_q   <= s1_sum_d;
      res_q      <= res_d;
      en_q       <= en_d;
      done_q     <= done_d;
    end
  end

  // Line buffers and window columns; stale contents are masked by the window-valid gating.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      lb_q[0][col_q] <= pixel_in;
      for (int j = 1; j < K-1; j++) lb_q[j][col_q] <= lb_q[j-1][col_q];
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K-2; c++) win_q[r][c] <= win_q[r][c+1];
        win_q[r][K-2] <= colv_s[r];
      end
    end
  end
endmodule

// File: tb/tb_convolver_stream_strided.sv
// Self-checking bench for convolver_stream_strided: table-driven uniform frames, stride-2 instance,
// random frames with backpressure and a mid-frame reset, all checked through scoreboard queues.
`timescale 1ns/1ps
module tb_convolver_stream_strided;
  localparam int N  = 28;
  localparam int K  = 5;
  localparam int DW = 16;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic [K*K*DW-1:0]   weights_matrix = '0;
  logic [DW-1:0]       bias = '0;
  logic [DW-1:0]       pixel_in = '0;
  logic                pixel_valid = 1'b0;
  logic                out_ready = 1'b1;
  logic                pixel_ready, enable_signal, frame_done;
  logic [DW-1:0]       conv_final_result;
  logic                out_ready2 = 1'b1;
  logic                pixel_ready2, enable2, done2;
  logic [DW-1:0]       result2;

  always #5 clk = ~clk;

  convolver_stream_strided #(.IMAGE_SIZE(N), .KERNEL_SIZE(K), .DATA_WIDTH(DW), .FRAC_BIT(8), .STRIDE(1)) dut (
    .clk(clk), .reset(reset), .weights_matrix(weights_matrix), .bias(bias),
    .pixel_in(pixel_in), .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
    .conv_final_result(conv_final_result), .enable_signal(enable_signal),
    .out_ready(out_ready), .frame_done(frame_done));

  convolver_stream_strided #(.IMAGE_SIZE(N), .KERNEL_SIZE(K), .DATA_WIDTH(DW), .FRAC_BIT(8), .STRIDE(2)) dut2 (
    .clk(clk), .reset(reset), .weights_matrix(weights_matrix), .bias(bias),
    .pixel_in(pixel_in), .pixel_valid(pixel_valid), .pixel_ready(pixel_ready2),
    .conv_final_result(result2), .enable_signal(enable2),
    .out_ready(out_ready2), .frame_done(done2));

  typedef struct { logic [DW-1:0] v; logic last; } exp_t;
  typedef struct { logic [DW-1:0] w; logic [DW-1:0] p; logic [DW-1:0] b; logic [DW-1:0] e; } vec_t;

  exp_t          q1[$];
  exp_t          q2[$];
  vec_t          tab[4];
  shortint       img[N][N];
  shortint       wt[K][K];
  shortint       bias_v;
  int            n_checks = 0, n_fail = 0;
  int            cyc = 0;
  int            br = 0, bc = 0, pidx = 0;
  int            n_res = 0, n_done = 0, n_res2 = 0;
  int            acc116 = 0, en1_first = -1, en2_first = -1;
  bit            chk2 = 1'b0, use_tab = 1'b0;
  logic [DW-1:0] tab_exp = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rnd_val(input int span);
    int v;
    v = int'($urandom_range(0, 2*span-1)) - span;
    return v[DW-1:0];
  endfunction

  function automatic bit win_ok(input int r, input int c, input int s);
    return (r >= K-1) && (c >= K-1) && ((r-K+1) % s == 0) && ((c-K+1) % s == 0);
  endfunction

  function automatic int last_pos(input int s);
    return (K-1) + ((N-K)/s)*s;
  endfunction

  function automatic logic [DW-1:0] model(input int r, input int c);
    longint acc;
    acc = 0;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        acc += longint'(img[r-K+1+i][c-K+1+j]) * longint'(wt[i][j]);
    acc += longint'(bias_v) * 256;
    acc += 128;
    acc = acc >>> 8;
    if (acc > 32767) acc = 32767;
    else if (acc < -32768) acc = -32768;
`ifdef RELU_EN
    if (acc < 0) acc = 0;
`endif
    return acc[DW-1:0];
  endfunction

  task automatic set_w();
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        weights_matrix[((K*K-1)-(r*K+c))*DW +: DW] = wt[r][c];
    bias = bias_v;
  endtask

  task automatic accept(input logic [DW-1:0] p);
    exp_t e;
    img[br][bc] = shortint'(p);
    if (pidx == 116) acc116 = cyc;
    if (win_ok(br, bc, 1)) begin
      e.v = use_tab ? tab_exp : model(br, bc);
      e.last = (br == last_pos(1)) && (bc == last_pos(1));
      q1.push_back(e);
    end
    if (chk2 && win_ok(br, bc, 2)) begin
      e.v = use_tab ? tab_exp : model(br, bc);
      e.last = (br == last_pos(2)) && (bc == last_pos(2));
      q2.push_back(e);
    end
    pidx++;
    bc++;
    if (bc == N) begin
      bc = 0;
      br++;
      if (br == N) begin
        br = 0;
        pidx = 0;
      end
    end
  endtask

  task automatic drive(input int n, input bit rnd, input logic [DW-1:0] val, input int stall_idx);
    int i = 0, guard = 0, stall_cnt = 0;
    bit stalled = 1'b0;
    logic [DW-1:0] cur;
    cur = rnd ? rnd_val(512) : val;
    while (i < n && guard < n + 200) begin
      if (!stalled && i == stall_idx) begin
        stalled = 1'b1;
        stall_cnt = 10;
      end
      out_ready = (stall_cnt == 0);
      if (stall_cnt > 0) stall_cnt--;
      pixel_valid = 1'b1;
      pixel_in = cur;
      @(negedge clk);
      if (pixel_ready) begin
        accept(cur);
        i++;
        cur = rnd ? rnd_val(512) : val;
      end
      @(posedge clk);
      #1;
      guard++;
    end
    pixel_valid = 1'b0;
    out_ready = 1'b1;
    if (i < n) check("drive_timeout", i, n);
  endtask

  task automatic drain();
    int t = 0;
    while ((q1.size() != 0 || (chk2 && q2.size() != 0)) && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("drain_q1", q1.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    pixel_valid = 1'b0;
    out_ready = 1'b1;
    q1.delete();
    q2.delete();
    br = 0;
    bc = 0;
    pidx = 0;
    @(negedge clk);
    check("rst_result", conv_final_result, 0);
    check("rst_enable", enable_signal, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_ready", pixel_ready, 0);
    check("rst_result2", result2, 0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("ready_after_reset", pixel_ready, 1);
  endtask

  task automatic monitor();
    logic [DW-1:0] held;
    bit held_v;
    exp_t e;
    held_v = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        held_v = 1'b0;
      end else begin
        if (enable_signal && !out_ready) begin
          check("stall_ready", pixel_ready, 0);
          if (held_v) check("stall_hold", conv_final_result, held);
          held = conv_final_result;
          held_v = 1'b1;
        end else begin
          held_v = 1'b0;
        end
        if (enable_signal && en1_first < 0) en1_first = cyc;
        if (enable_signal && out_ready) begin
          n_res++;
          if (frame_done) n_done++;
          if (q1.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_result: got %h expected none", conv_final_result);
          end else begin
            e = q1.pop_front();
            check("result", conv_final_result, e.v);
            check("frame_done", frame_done, e.last);
          end
        end
        if (chk2 && enable2) begin
          n_res2++;
          if (en2_first < 0) en2_first = cyc;
          if (q2.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_result2: got %h expected none", result2);
          end else begin
            e = q2.pop_front();
            check("result2", result2, e.v);
            check("frame_done2", done2, e.last);
          end
        end
      end
    end
  endtask

  initial begin
    tab[0] = '{16'h0100, 16'h0100, 16'h0000, 16'h1900};
    tab[1] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
`ifdef RELU_EN
    tab[2] = '{16'h8000, 16'h7FFF, 16'h0000, 16'h0000};
    tab[3] = '{16'hFF00, 16'h0100, 16'h0000, 16'h0000};
`else
    tab[2] = '{16'h8000, 16'h7FFF, 16'h0000, 16'h8000};
    tab[3] = '{16'hFF00, 16'h0100, 16'h0000, 16'hE700};
`endif
    fork
      forever begin
        @(posedge clk);
        cyc++;
      end
      monitor();
      begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
      end
    join_none

    do_reset();

    for (int t = 0; t < 4; t++) begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++) wt[r][c] = shortint'(tab[t].w);
      bias_v = shortint'(tab[t].b);
      set_w();
      use_tab = 1'b1;
      tab_exp = tab[t].e;
      chk2 = (t == 0);
      n_res = 0;
      n_done = 0;
      n_res2 = 0;
      en1_first = -1;
      en2_first = -1;
      drive(N*N, 1'b0, tab[t].p, -1);
      drain();
      check("frame_count", n_res, 576);
      check("frame_done_count", n_done, 1);
      if (t == 0) begin
        check("stride2_count", n_res2, 144);
        check("stride2_drain", q2.size(), 0);
        check("latency_s1", en1_first - acc116, 2);
        check("latency_s2", en2_first - acc116, 2);
      end
      chk2 = 1'b0;
    end

    use_tab = 1'b0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++) wt[r][c] = shortint'(rnd_val(256));
    bias_v = shortint'(rnd_val(512));
    set_w();
    n_res = 0;
    n_done = 0;
    drive(2*N*N, 1'b1, 16'h0000, 400);
    drain();
    check("random_count", n_res, 1152);
    check("random_done_count", n_done, 2);

    drive(300, 1'b1, 16'h0000, -1);
    do_reset();
    n_res = 0;
    n_done = 0;
    drive(N*N, 1'b1, 16'h0000, -1);
    drain();
    check("post_reset_count", n_res, 576);
    check("post_reset_done_count", n_done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
